// File: rtl/video_timing_pipe_if.sv
// Pixel-source request bus and aligned video output bus of video_timing_pipe.
// master = timing generator, slave = pixel source / TMDS encoder side.
interface video_timing_pipe_if #(
    parameter int CW     = 12,
    parameter int ADDR_W = 26
);
    // request side towards the pixel source
    logic [CW-1:0]     cntX;
    logic [CW-1:0]     cntY;
    logic              req_valid;
    logic [ADDR_W-1:0] adress;
    // source data, PIX_LATENCY cycles behind the request
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    // aligned outputs towards the encoders
    logic [7:0]        red_o;
    logic [7:0]        green_o;
    logic [7:0]        blue_o;
    logic              hsync_o;
    logic              vsync_o;
    logic              de_o;
    logic              frame_start;
    logic              line_start;

    modport master (
        output cntX, cntY, req_valid, adress,
        input  red, green, blue,
        output red_o, green_o, blue_o, hsync_o, vsync_o, de_o, frame_start, line_start
    );

    modport slave (
        input  cntX, cntY, req_valid, adress,
        output red, green, blue,
        input  red_o, green_o, blue_o, hsync_o, vsync_o, de_o, frame_start, line_start
    );
endinterface

// File: rtl/video_timing_pipe.sv
// Raster timing generator: requests pixels by x/y/address, re-aligns sync/DE with returned RGB.
// Output latency PIX_LATENCY+1 from cntX/cntY; no backpressure. Colour bars under VIDEO_TIMING_TESTPAT_EN.
module video_timing_pipe #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0,
    parameter int CW          = 12,
    parameter int ADDR_W      = 26,
    parameter int PIX_LATENCY = 2
) (
    input  logic clk_low,
    input  logic reset,
    input  logic en,
`ifdef VIDEO_TIMING_TESTPAT_EN
    input  logic test_pattern,
`endif
    video_timing_pipe_if.master vif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS_C   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS_C   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOT - 1);

    localparam logic H_POL_B = (H_POL != 0);
    localparam logic V_POL_B = (V_POL != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } ctl_t;

    localparam ctl_t CTL_BLANK = '{hs: ~H_POL_B, vs: ~V_POL_B, de: 1'b0, fs: 1'b0, ls: 1'b0};

    logic              run;
    logic [CW-1:0]     h_q, h_d;
    logic [CW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              h_wrap;
    logic              v_wrap;
    logic              req_valid;

    assign run       = en && !reset;
    assign h_wrap    = (h_q == H_LAST_C);
    assign v_wrap    = (v_q == V_LAST_C);
    assign req_valid = (h_q < H_ACT_C) && (v_q < V_ACT_C);

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        adr_d = adr_q;
        if (!run) begin
            h_d   = '0;
            v_d   = '0;
            adr_d = '0;
        end else begin
            h_d = h_wrap ? '0 : h_q + CW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end
            // address advances after each requested pixel, so it holds through blanking
            if (h_wrap && v_wrap) begin
                adr_d = '0;
            end else if (req_valid) begin
                adr_d = adr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_low) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            adr_q <= '0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            adr_q <= adr_d;
        end
    end

    assign vif.cntX      = h_q;
    assign vif.cntY      = v_q;
    assign vif.req_valid = req_valid;
    assign vif.adress    = adr_q;

    ctl_t raw;

    always_comb begin
        raw    = CTL_BLANK;
        raw.hs = ((h_q >= H_SS_C) && (h_q < H_SE_C)) ? H_POL_B : ~H_POL_B;
        raw.vs = ((v_q >= V_SS_C) && (v_q < V_SE_C)) ? V_POL_B : ~V_POL_B;
        raw.de = req_valid;
        raw.fs = (h_q == '0) && (v_q == '0);
        raw.ls = (h_q == '0) && (v_q < V_ACT_C);
    end

    // tap[k] is the control word k cycles after the request; tap[PIX_LATENCY] lines up with source data
    ctl_t pipe_q [PIX_LATENCY+1];
    ctl_t tap    [PIX_LATENCY+2];

    always_comb begin
        tap[0] = raw;
        for (int k = 1; k <= PIX_LATENCY + 1; k++) begin
            tap[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk_low) begin
        if (reset || !en) begin
            for (int k = 0; k <= PIX_LATENCY; k++) begin
                pipe_q[k] <= CTL_BLANK;
            end
        end else begin
            for (int k = 0; k <= PIX_LATENCY; k++) begin
                pipe_q[k] <= tap[k];
            end
        end
    end

    logic [23:0] src_rgb;

`ifdef VIDEO_TIMING_TESTPAT_EN
    localparam logic [CW-1:0] BAR_LAST_C = CW'(H_ACTIVE / 8 - 1);

    logic [CW-1:0] bar_px_q;
    logic [2:0]    bar_idx_q;
    logic [23:0]   bar_rgb;
    logic [24:0]   tp_now;
    logic [24:0]   tp_dly;

    // bar index advances every H_ACTIVE/8 requested pixels and wraps to 0 after the 8th bar
    always_ff @(posedge clk_low) begin
        if (reset || !en) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else if (req_valid) begin
            if (bar_px_q == BAR_LAST_C) begin
                bar_px_q  <= '0;
                bar_idx_q <= bar_idx_q + 3'd1;
            end else begin
                bar_px_q <= bar_px_q + CW'(1);
            end
        end
    end

    // white, yellow, cyan, green, magenta, red, blue, black
    assign bar_rgb = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
    assign tp_now  = {test_pattern, bar_rgb};

    if (PIX_LATENCY == 0) begin : g_tp_nodly
        assign tp_dly = tp_now;
    end else begin : g_tp_dly
        logic [24:0] tp_pipe_q [PIX_LATENCY];

        always_ff @(posedge clk_low) begin
            if (reset) begin
                for (int k = 0; k < PIX_LATENCY; k++) begin
                    tp_pipe_q[k] <= '0;
                end
            end else begin
                tp_pipe_q[0] <= tp_now;
                for (int k = 1; k < PIX_LATENCY; k++) begin
                    tp_pipe_q[k] <= tp_pipe_q[k-1];
                end
            end
        end

        assign tp_dly = tp_pipe_q[PIX_LATENCY-1];
    end

    assign src_rgb = tp_dly[24] ? tp_dly[23:0] : {vif.red, vif.green, vif.blue};
`else
    assign src_rgb = {vif.red, vif.green, vif.blue};
`endif

    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (run && tap[PIX_LATENCY].de) begin
            rgb_d = src_rgb;
        end
    end

    always_ff @(posedge clk_low) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vif.red_o       = rgb_q[23:16];
    assign vif.green_o     = rgb_q[15:8];
    assign vif.blue_o      = rgb_q[7:0];
    assign vif.hsync_o     = tap[PIX_LATENCY+1].hs;
    assign vif.vsync_o     = tap[PIX_LATENCY+1].vs;
    assign vif.de_o        = tap[PIX_LATENCY+1].de;
    assign vif.frame_start = tap[PIX_LATENCY+1].fs;
    assign vif.line_start  = tap[PIX_LATENCY+1].ls;

endmodule

// File: tb/tb_video_timing_pipe.sv
// Directed bench for video_timing_pipe on a reduced 24x8 raster, both sync polarities side by side.
module tb_video_timing_pipe;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LAT = 2;

    logic clk_low;
    logic reset;
    logic en;
    int   tests;
    int   fails;

    video_timing_pipe_if #(.CW(12), .ADDR_W(26)) if0 ();
    video_timing_pipe_if #(.CW(12), .ADDR_W(26)) if1 ();

`ifdef VIDEO_TIMING_TESTPAT_EN
    logic        tp_on;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    video_timing_pipe #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .CW(12), .ADDR_W(26), .PIX_LATENCY(LAT)
    ) dut0 (
        .clk_low(clk_low),
        .reset(reset),
        .en(en),
`ifdef VIDEO_TIMING_TESTPAT_EN
        .test_pattern(tp_on),
`endif
        .vif(if0)
    );

    video_timing_pipe #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1), .V_POL(1), .CW(12), .ADDR_W(26), .PIX_LATENCY(LAT)
    ) dut1 (
        .clk_low(clk_low),
        .reset(reset),
        .en(en),
`ifdef VIDEO_TIMING_TESTPAT_EN
        .test_pattern(tp_on),
`endif
        .vif(if1)
    );

    // external pixel source: echoes the request two cycles later
    logic [23:0] src1, src2;
    always @(posedge clk_low) begin
        src1 <= {if0.cntX[7:0], if0.cntY[7:0], if0.cntX[7:0] ^ 8'h5A};
        src2 <= src1;
    end
    assign if0.red   = src2[23:16];
    assign if0.green = src2[15:8];
    assign if0.blue  = src2[7:0];
    assign if1.red   = src2[23:16];
    assign if1.green = src2[15:8];
    assign if1.blue  = src2[7:0];

    initial clk_low = 1'b0;
    always #5 clk_low = ~clk_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_low);
        #1;
    endtask

    // c = cycles since the counters last sat at h=0,v=0 with the block running
    task automatic check_cycle(input int c);
        int h, v, p, x, y;
        bit hs_a, vs_a, de_e, fs_e, ls_e;
        logic [23:0] rgb_e;
        h = c % HT;
        v = (c / HT) % VT;
        check("cntX", 32'(if0.cntX), 32'(h));
        check("cntY", 32'(if0.cntY), 32'(v));
        check("req_valid", 32'(if0.req_valid), 32'(h < HA && v < VA));
        if (h < HA && v < VA) check("adress", 32'(if0.adress), 32'(v * HA + h));
        p = c - (LAT + 1);
        x = 0;
        y = 0;
        if (p < 0) begin
            hs_a = 0; vs_a = 0; de_e = 0; fs_e = 0; ls_e = 0;
        end else begin
            x = p % HT;
            y = (p / HT) % VT;
            hs_a = (x >= HA + HF) && (x < HA + HF + HS);
            vs_a = (y >= VA + VF) && (y < VA + VF + VS);
            de_e = (x < HA) && (y < VA);
            fs_e = (x == 0) && (y == 0);
            ls_e = (x == 0) && (y < VA);
        end
        rgb_e = 24'h0;
        if (de_e) begin
`ifdef VIDEO_TIMING_TESTPAT_EN
            rgb_e = tp_on ? bars[x / 2] : {8'(x), 8'(y), 8'(x) ^ 8'h5A};
`else
            rgb_e = {8'(x), 8'(y), 8'(x) ^ 8'h5A};
`endif
        end
        check("hsync_o", 32'(if0.hsync_o), 32'(!hs_a));
        check("vsync_o", 32'(if0.vsync_o), 32'(!vs_a));
        check("de_o", 32'(if0.de_o), 32'(de_e));
        check("rgb_o", 32'({if0.red_o, if0.green_o, if0.blue_o}), 32'(rgb_e));
        check("frame_start", 32'(if0.frame_start), 32'(fs_e));
        check("line_start", 32'(if0.line_start), 32'(ls_e));
        check("hsync_o_pos", 32'(if1.hsync_o), 32'(hs_a));
        check("vsync_o_pos", 32'(if1.vsync_o), 32'(vs_a));
        check("de_o_pos", 32'(if1.de_o), 32'(de_e));
    endtask

    initial begin
        int c, guard, first_fall;
        int hs_low, vs_low, de_cnt, fs_cnt, ls_cnt, hs_high_pos;
        logic prev_hs;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        en    = 1'b0;
`ifdef VIDEO_TIMING_TESTPAT_EN
        tp_on = 1'b0;
`endif
        repeat (5) step();
        check("rst_cntX", 32'(if0.cntX), 32'd0);
        check("rst_adress", 32'(if0.adress), 32'd0);
        check("rst_hsync_o", 32'(if0.hsync_o), 32'd1);
        check("rst_hsync_o_pos", 32'(if1.hsync_o), 32'd0);
        check("rst_de_o", 32'(if0.de_o), 32'd0);
        check("rst_red_o", 32'(if0.red_o), 32'd0);

        // released from reset but not enabled: still idle
        reset = 1'b0;
        repeat (2) step();
        check_cycle(0);
        step();
        check_cycle(0);

        en = 1'b1;
        hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0; ls_cnt = 0; hs_high_pos = 0;
        first_fall = -1;
        prev_hs = 1'b1;
        for (c = 0; c < 420; c++) begin
            check_cycle(c);
            if (c >= LAT + 1 && c < LAT + 1 + 2 * HT * VT) begin
                hs_low      += (if0.hsync_o == 1'b0) ? 1 : 0;
                vs_low      += (if0.vsync_o == 1'b0) ? 1 : 0;
                de_cnt      += (if0.de_o == 1'b1) ? 1 : 0;
                fs_cnt      += (if0.frame_start == 1'b1) ? 1 : 0;
                ls_cnt      += (if0.line_start == 1'b1) ? 1 : 0;
                hs_high_pos += (if1.hsync_o == 1'b1) ? 1 : 0;
            end
            if (first_fall < 0 && prev_hs && !if0.hsync_o) first_fall = c;
            prev_hs = if0.hsync_o;
            step();
        end
        check("first_hsync_fall", 32'(first_fall), 32'(HA + HF + LAT + 1));
        check("hsync_low_2frames", 32'(hs_low), 32'(2 * VT * HS));
        check("vsync_low_2frames", 32'(vs_low), 32'(2 * VS * HT));
        check("de_2frames", 32'(de_cnt), 32'(2 * HA * VA));
        check("frame_start_2frames", 32'(fs_cnt), 32'd2);
        check("line_start_2frames", 32'(ls_cnt), 32'(2 * VA));
        check("hsync_high_pos_2frames", 32'(hs_high_pos), 32'(2 * VT * HS));

        // one-cycle reset while in hsync on a vsync line
        guard = 0;
        while (!((c % HT) == 19 && ((c / HT) % VT) == 5) && guard < 2 * HT * VT) begin
            check_cycle(c);
            step();
            c++;
            guard++;
        end
        check("reach_reset_point", 32'(if0.cntX), 32'd19);
        reset = 1'b1;
`ifdef VIDEO_TIMING_TESTPAT_EN
        tp_on = 1'b1;
`endif
        step();
        reset = 1'b0;
        for (c = 0; c < 220; c++) begin
            check_cycle(c);
            step();
        end

        // drop enable mid-line for two cycles
        en = 1'b0;
        step();
        check_cycle(0);
        step();
        check_cycle(0);
        en = 1'b1;
        for (c = 0; c < 100; c++) begin
            check_cycle(c);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
